multicycle_control_unit: RTL and testbench

Multicycle main-control FSM for the RV32I core: sequences each instruction over 3–5 states, sharing one ALU and one unified instruction/data memory port. Emits datapath selects/enables plus a 2-bit ALUOp for the existing combinational ALU decoder. Adds a memory ready/valid handshake with a wait-state timeout, JAL/LUI support, and a sticky trap state for illegal opcodes or bus errors.

---
 rtl/multicycle_control_unit_if.sv | 42 ++++
 rtl/multicycle_control_unit.sv | 268 ++++++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_unit_if.sv
// Purpose : bundle of control-unit <-> datapath/memory signals for the RV32I
//           multicycle core.
// Signals : opcode/funct3/zero/mem_ready  datapath and memory -> control unit
//           mem_valid, MemWrite, IRWrite, PCWrite, AdrSrc, RegWrite,
//           ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUOp, instr_done,
//           halted, bus_error              control unit -> datapath and memory
// Modports: master = control unit side, slave = datapath/memory side.
interface multicycle_control_unit_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       zero;
    logic       mem_ready;

    logic       mem_valid;
    logic       MemWrite;
    logic       IRWrite;
    logic       PCWrite;
    logic       AdrSrc;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ImmSrc;
    logic [1:0] ALUOp;
    logic       instr_done;
    logic       halted;
    logic       bus_error;

    modport master (
        input  opcode, funct3, zero, mem_ready,
        output mem_valid, MemWrite, IRWrite, PCWrite, AdrSrc, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUOp,
               instr_done, halted, bus_error
    );

    modport slave (
        output opcode, funct3, zero, mem_ready,
        input  mem_valid, MemWrite, IRWrite, PCWrite, AdrSrc, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUOp,
               instr_done, halted, bus_error
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Purpose : main-control FSM of the RV32I multicycle core. Sequences each
//           instruction over 3-5 states on a shared ALU and a unified memory
//           port with a ready/valid handshake, a wait-state timeout and a
//           sticky TRAP state (illegal opcode or bus timeout).
// Ports   : clk  rising-edge clock
//           rst  asynchronous active-high reset
//           bus  multicycle_control_unit_if.master (decode inputs, memory
//                handshake, datapath selects/enables, status)
// Params  : MEM_TIMEOUT  max consecutive memory wait cycles before bus error
//                        (0 disables the timeout)
// Macro   : CU_JALR_EN   adds JALR (opcode 1100111) via JALR/JALRPC states;
//                        without it that opcode traps as illegal.
module multicycle_control_unit #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic                             clk,
    input  logic                             rst,
    multicycle_control_unit_if.master        bus
);
    localparam int unsigned CNT_W      = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam bit          TIMEOUT_EN = (MEM_TIMEOUT > 0);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
`ifdef CU_JALR_EN
    localparam logic [6:0] OP_JALR   = 7'b1100111;
`endif

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_LUI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
`ifdef CU_JALR_EN
        S_JALR,
        S_JALRPC,
`endif
        S_TRAP
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_next;
    logic             bus_error_q;
    logic             mem_access_c;
    logic             timeout_c;

    logic             mem_valid_c;
    logic             mem_write_c;
    logic             ir_write_c;
    logic             pc_write_c;
    logic             adr_src_c;
    logic             reg_write_c;
    logic [1:0]       result_src_c;
    logic [1:0]       alu_src_a_c;
    logic [1:0]       alu_src_b_c;
    logic [2:0]       imm_src_c;
    logic [1:0]       alu_op_c;
    logic             instr_done_c;
    logic             halted_c;

    // funct3[2:1] only matter to the ALU decoder, not to sequencing.
    logic             unused_c;
    assign unused_c = ^bus.funct3[2:1];

    // Memory-access states: the only ones where the wait counter runs.
    assign mem_access_c = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);

    // A ready in the final allowed wait cycle still completes the access.
    assign timeout_c = TIMEOUT_EN && mem_access_c && !bus.mem_ready &&
                       (wait_cnt == CNT_W'(MEM_TIMEOUT));

    // State register, wait counter and sticky bus-error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_FETCH;
            wait_cnt    <= '0;
            bus_error_q <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (timeout_c) begin
                bus_error_q <= 1'b1;
            end
        end
    end

    // Next-state and next wait count.
    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:    if (bus.mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE:          state_next = S_EXECR;
                    OP_ITYPE:          state_next = S_EXECI;
                    OP_BRANCH:         state_next = S_BRANCH;
                    OP_JAL:            state_next = S_JAL;
                    OP_LUI:            state_next = S_LUI;
`ifdef CU_JALR_EN
                    OP_JALR:           state_next = S_JALR;
`endif
                    default:           state_next = S_TRAP;
                endcase
            end
            S_MEMADR:   state_next = (bus.opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (bus.mem_ready) state_next = S_MEMWB;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: if (bus.mem_ready) state_next = S_FETCH;
            S_EXECR:    state_next = S_ALUWB;
            S_EXECI:    state_next = S_ALUWB;
            S_LUI:      state_next = S_ALUWB;
            S_ALUWB:    state_next = S_FETCH;
            S_BRANCH:   state_next = S_FETCH;
            S_JAL:      state_next = S_ALUWB;
`ifdef CU_JALR_EN
            S_JALR:     state_next = S_JALRPC;
            S_JALRPC:   state_next = S_ALUWB;
`endif
            S_TRAP:     state_next = S_TRAP;
            default:    state_next = S_TRAP;
        endcase
        if (timeout_c) begin
            state_next = S_TRAP;
        end

        wait_cnt_next = '0;
        if (mem_access_c && !bus.mem_ready && (state_next == state)) begin
            wait_cnt_next = wait_cnt + CNT_W'(1);
        end
    end

    // Datapath controls, decoded from state (Mealy on mem_ready/zero).
    always_comb begin
        mem_valid_c  = 1'b0;
        mem_write_c  = 1'b0;
        ir_write_c   = 1'b0;
        pc_write_c   = 1'b0;
        adr_src_c    = 1'b0;
        reg_write_c  = 1'b0;
        result_src_c = 2'b00;
        alu_src_a_c  = 2'b00;
        alu_src_b_c  = 2'b00;
        imm_src_c    = 3'b000;
        alu_op_c     = 2'b00;
        instr_done_c = 1'b0;
        halted_c     = 1'b0;
        case (state)
            S_FETCH: begin
                mem_valid_c  = 1'b1;
                ir_write_c   = bus.mem_ready;
                pc_write_c   = bus.mem_ready;
                result_src_c = 2'b10;
                alu_src_b_c  = 2'b10;
            end
            S_DECODE: begin
                alu_src_a_c = 2'b01;
                alu_src_b_c = 2'b01;
                imm_src_c   = (bus.opcode == OP_JAL) ? 3'b011 : 3'b010;
            end
            S_MEMADR: begin
                alu_src_a_c = 2'b10;
                alu_src_b_c = 2'b01;
                imm_src_c   = (bus.opcode == OP_STORE) ? 3'b001 : 3'b000;
            end
            S_MEMREAD: begin
                mem_valid_c = 1'b1;
                adr_src_c   = 1'b1;
            end
            S_MEMWB: begin
                result_src_c = 2'b01;
                reg_write_c  = 1'b1;
                instr_done_c = 1'b1;
            end
            S_MEMWRITE: begin
                mem_valid_c  = 1'b1;
                mem_write_c  = 1'b1;
                adr_src_c    = 1'b1;
                instr_done_c = bus.mem_ready;
            end
            S_EXECR: begin
                alu_src_a_c = 2'b10;
                alu_op_c    = 2'b10;
            end
            S_EXECI: begin
                alu_src_a_c = 2'b10;
                alu_src_b_c = 2'b01;
                alu_op_c    = 2'b10;
            end
            S_LUI: begin
                alu_src_a_c = 2'b11;
                alu_src_b_c = 2'b01;
                imm_src_c   = 3'b100;
            end
            S_ALUWB: begin
                reg_write_c  = 1'b1;
                instr_done_c = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_c  = 2'b10;
                alu_op_c     = 2'b01;
                pc_write_c   = bus.zero ^ bus.funct3[0];
                instr_done_c = 1'b1;
            end
            S_JAL: begin
                alu_src_a_c = 2'b01;
                alu_src_b_c = 2'b10;
                pc_write_c  = 1'b1;
            end
`ifdef CU_JALR_EN
            S_JALR: begin
                alu_src_a_c = 2'b10;
                alu_src_b_c = 2'b01;
            end
            S_JALRPC: begin
                alu_src_a_c = 2'b01;
                alu_src_b_c = 2'b10;
                pc_write_c  = 1'b1;
            end
`endif
            S_TRAP: begin
                halted_c = 1'b1;
            end
            default: begin
                halted_c = 1'b0;
            end
        endcase
        // Reset is asynchronous, so strobes must drop without waiting for an edge.
        if (rst) begin
            mem_valid_c  = 1'b0;
            mem_write_c  = 1'b0;
            ir_write_c   = 1'b0;
            pc_write_c   = 1'b0;
            reg_write_c  = 1'b0;
            instr_done_c = 1'b0;
        end
    end

    assign bus.mem_valid  = mem_valid_c;
    assign bus.MemWrite   = mem_write_c;
    assign bus.IRWrite    = ir_write_c;
    assign bus.PCWrite    = pc_write_c;
    assign bus.AdrSrc     = adr_src_c;
    assign bus.RegWrite   = reg_write_c;
    assign bus.ResultSrc  = result_src_c;
    assign bus.ALUSrcA    = alu_src_a_c;
    assign bus.ALUSrcB    = alu_src_b_c;
    assign bus.ImmSrc     = imm_src_c;
    assign bus.ALUOp      = alu_op_c;
    assign bus.instr_done = instr_done_c;
    assign bus.halted     = halted_c;
    assign bus.bus_error  = bus_error_q;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Purpose : self-checking bench for multicycle_control_unit (MEM_TIMEOUT=3).
//           Directed instruction sequences push the expected 20-bit control
//           vector for each cycle; a negedge monitor pops and compares.
// Vector  : {mem_valid, MemWrite, IRWrite, PCWrite, AdrSrc, RegWrite,
//            ResultSrc[1:0], ALUSrcA[1:0], ALUSrcB[1:0], ImmSrc[2:0],
//            ALUOp[1:0], instr_done, halted, bus_error}
module tb_multicycle_control_unit;
    localparam int unsigned TIMEOUT  = 3;
    localparam logic [19:0] ALL_MASK = 20'hFFFFF;
    // Enables/strobes plus halted/bus_error; selects are don't-care in reset.
    localparam logic [19:0] RST_MASK = 20'hF4007;

    typedef struct {
        string       name;
        logic [19:0] exp;
        logic [19:0] mask;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    exp_t q[$];
    int   checks = 0;
    int   passed = 0;

    multicycle_control_unit_if bus ();

    multicycle_control_unit #(.MEM_TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] ev(bit mv, bit mw, bit irw, bit pcw, bit adr, bit rw,
                                       bit [1:0] rs, bit [1:0] sa, bit [1:0] sb,
                                       bit [2:0] imm, bit [1:0] aop,
                                       bit done, bit halt, bit berr);
        return {mv, mw, irw, pcw, adr, rw, rs, sa, sb, imm, aop, done, halt, berr};
    endfunction

    function automatic logic [19:0] v_fetch(bit r);
        return ev(1, 0, r, r, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0, 0, 0);
    endfunction
    function automatic logic [19:0] v_decode(bit [2:0] imm);
        return ev(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 2'b00, 0, 0, 0);
    endfunction
    function automatic logic [19:0] v_memadr(bit [2:0] imm);
        return ev(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, imm, 2'b00, 0, 0, 0);
    endfunction
    function automatic logic [19:0] v_memread();
        return ev(1, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0, 0);
    endfunction
    function automatic logic [19:0] v_memwb();
        return ev(0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00, 1, 0, 0);
    endfunction
    function automatic logic [19:0] v_memwrite(bit r);
        return ev(1, 1, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, r, 0, 0);
    endfunction
    function automatic logic [19:0] v_execr();
        return ev(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 2'b10, 0, 0, 0);
    endfunction
    function automatic logic [19:0] v_execi();
        return ev(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b10, 0, 0, 0);
    endfunction
    function automatic logic [19:0] v_lui();
        return ev(0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 2'b01, 3'b100, 2'b00, 0, 0, 0);
    endfunction
    function automatic logic [19:0] v_aluwb();
        return ev(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1, 0, 0);
    endfunction
    function automatic logic [19:0] v_branch(bit p);
        return ev(0, 0, 0, p, 0, 0, 2'b00, 2'b10, 2'b00, 3'b000, 2'b01, 1, 0, 0);
    endfunction
    function automatic logic [19:0] v_jal();
        return ev(0, 0, 0, 1, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 2'b00, 0, 0, 0);
    endfunction
    function automatic logic [19:0] v_trap(bit berr);
        return ev(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0, 1, berr);
    endfunction
`ifdef CU_JALR_EN
    function automatic logic [19:0] v_jalr();
        return ev(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 0, 0, 0);
    endfunction
`endif

    function automatic logic [19:0] actual();
        return {bus.mem_valid, bus.MemWrite, bus.IRWrite, bus.PCWrite, bus.AdrSrc,
                bus.RegWrite, bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc,
                bus.ALUOp, bus.instr_done, bus.halted, bus.bus_error};
    endfunction

    task automatic check(input string name, input logic [19:0] act,
                         input logic [19:0] exp, input logic [19:0] mask);
        checks++;
        if ((act & mask) !== (exp & mask)) begin
            $display("FAIL %s @%0t: got %05h expected %05h (mask %05h)",
                     name, $time, act & mask, exp & mask, mask);
        end else begin
            passed++;
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check(e.name, actual(), e.exp, e.mask);
        end
    end

    // Drive one cycle of inputs (called just after a posedge), queue its expectation.
    task automatic step(input bit r, input bit z, input logic [19:0] e, input string n);
        bus.mem_ready = r;
        bus.zero      = z;
        q.push_back('{name: n, exp: e, mask: ALL_MASK});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.mem_ready = 1'b1;
        q.push_back('{name: "reset", exp: 20'h00000, mask: RST_MASK});
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3);
        bus.opcode = op;
        bus.funct3 = f3;
    endtask

    initial begin
        rst           = 1'b1;
        bus.opcode    = 7'b0110011;
        bus.funct3    = 3'b000;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // R-type add
        set_instr(7'b0110011, 3'b000);
        step(1, 0, v_fetch(1), "r_fetch");
        step(1, 0, v_decode(3'b010), "r_decode");
        step(1, 0, v_execr(), "r_execr");
        step(1, 0, v_aluwb(), "r_aluwb");

        // load with two wait cycles in MEMREAD
        set_instr(7'b0000011, 3'b010);
        step(1, 0, v_fetch(1), "ld_fetch");
        step(1, 0, v_decode(3'b010), "ld_decode");
        step(1, 0, v_memadr(3'b000), "ld_memadr");
        step(0, 0, v_memread(), "ld_wait1");
        step(0, 0, v_memread(), "ld_wait2");
        step(1, 0, v_memread(), "ld_read");
        step(1, 0, v_memwb(), "ld_memwb");

        // store, zero wait
        set_instr(7'b0100011, 3'b010);
        step(1, 0, v_fetch(1), "st_fetch");
        step(1, 0, v_decode(3'b010), "st_decode");
        step(1, 0, v_memadr(3'b001), "st_memadr");
        step(1, 0, v_memwrite(1), "st_write");

        // I-type
        set_instr(7'b0010011, 3'b000);
        step(1, 0, v_fetch(1), "i_fetch");
        step(1, 0, v_decode(3'b010), "i_decode");
        step(1, 0, v_execi(), "i_execi");
        step(1, 0, v_aluwb(), "i_aluwb");

        // LUI
        set_instr(7'b0110111, 3'b000);
        step(1, 0, v_fetch(1), "lui_fetch");
        step(1, 0, v_decode(3'b010), "lui_decode");
        step(1, 0, v_lui(), "lui_exec");
        step(1, 0, v_aluwb(), "lui_aluwb");

        // BNE not equal -> taken, BNE equal -> not taken, BEQ equal -> taken
        set_instr(7'b1100011, 3'b001);
        step(1, 0, v_fetch(1), "bne_fetch");
        step(1, 0, v_decode(3'b010), "bne_decode");
        step(1, 0, v_branch(1), "bne_taken");
        step(1, 1, v_fetch(1), "bne2_fetch");
        step(1, 1, v_decode(3'b010), "bne2_decode");
        step(1, 1, v_branch(0), "bne_not_taken");
        set_instr(7'b1100011, 3'b000);
        step(1, 1, v_fetch(1), "beq_fetch");
        step(1, 1, v_decode(3'b010), "beq_decode");
        step(1, 1, v_branch(1), "beq_taken");

        // JAL
        set_instr(7'b1101111, 3'b000);
        step(1, 0, v_fetch(1), "jal_fetch");
        step(1, 0, v_decode(3'b011), "jal_decode");
        step(1, 0, v_jal(), "jal_pc");
        step(1, 0, v_aluwb(), "jal_aluwb");

        // load: ready arrives in the last allowed wait cycle, access completes
        set_instr(7'b0000011, 3'b010);
        step(1, 0, v_fetch(1), "ldb_fetch");
        step(1, 0, v_decode(3'b010), "ldb_decode");
        step(1, 0, v_memadr(3'b000), "ldb_memadr");
        step(0, 0, v_memread(), "ldb_wait1");
        step(0, 0, v_memread(), "ldb_wait2");
        step(0, 0, v_memread(), "ldb_wait3");
        step(1, 0, v_memread(), "ldb_ready_at_limit");
        step(1, 0, v_memwb(), "ldb_memwb");

        // JALR
        set_instr(7'b1100111, 3'b000);
        step(1, 0, v_fetch(1), "jalr_fetch");
        step(1, 0, v_decode(3'b010), "jalr_decode");
`ifdef CU_JALR_EN
        step(1, 0, v_jalr(), "jalr_addr");
        step(1, 0, v_jal(), "jalr_pc");
        step(1, 0, v_aluwb(), "jalr_aluwb");
`else
        step(1, 0, v_trap(0), "jalr_illegal_trap");
        do_reset();
`endif

        // store stalled, then an asynchronous reset pulse mid-cycle
        set_instr(7'b0100011, 3'b010);
        step(1, 0, v_fetch(1), "sr_fetch");
        step(1, 0, v_decode(3'b010), "sr_decode");
        step(1, 0, v_memadr(3'b001), "sr_memadr");
        step(0, 0, v_memwrite(0), "sr_wait");
        bus.mem_ready = 1'b0;
        q.push_back('{name: "rst_release_fetch", exp: v_fetch(0), mask: ALL_MASK});
        rst = 1'b1;
        #1;
        check("rst_async_drop", actual(), 20'h00000, 20'hC0000);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // illegal opcode
        set_instr(7'b0000000, 3'b000);
        step(1, 0, v_fetch(1), "ill_fetch");
        step(1, 0, v_decode(3'b010), "ill_decode");
        step(1, 0, v_trap(0), "ill_trap");
        step(1, 0, v_trap(0), "ill_trap_sticky");
        do_reset();

        // FETCH timeout: four wait cycles then TRAP with bus_error
        set_instr(7'b0110011, 3'b000);
        step(0, 0, v_fetch(0), "to_wait1");
        step(0, 0, v_fetch(0), "to_wait2");
        step(0, 0, v_fetch(0), "to_wait3");
        step(0, 0, v_fetch(0), "to_wait4");
        step(0, 0, v_trap(1), "to_trap");
        step(1, 0, v_trap(1), "to_trap_sticky");
        do_reset();
        step(1, 0, v_fetch(1), "post_reset_fetch");
        step(1, 0, v_decode(3'b010), "post_reset_decode");

        for (int i = 0; i < 4 && q.size() > 0; i++) begin
            @(posedge clk);
        end
        if (q.size() > 0) begin
            checks++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
